// File: rtl/accum_pkg.sv
// Shared op codes and FSM state encoding for the accumulator register and its
// arithmetic helper.
package accum_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_CLR  = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/accum_addsub.sv
// Combinational signed add/subtract with overflow flag and optional clamp.
// Kept free of state so the ALU can reuse it directly.
module accum_addsub #(
  parameter int WIDTH = 16,
  parameter int SAT   = 0
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    sub,
  output logic signed [WIDTH-1:0] result,
  output logic                    ovf
);

  logic signed [WIDTH:0] ext;

  // Top two bits of the widened result disagree exactly when the sum left range.
  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH:0] x);
    if (x[WIDTH] != x[WIDTH-1]) begin
      return x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    return x[WIDTH-1:0];
  endfunction

  always_comb begin
    ext = '0;
    if (sub) ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    else     ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    ovf    = ext[WIDTH] ^ ext[WIDTH-1];
    result = (SAT != 0) ? saturate(ext) : ext[WIDTH-1:0];
  end

endmodule

// File: rtl/accum_reg.sv
// Accumulator register with hold/load/add/sub/clear, overflow tracking and a
// block counter that pulses done after every BLOCK_LEN add/sub operations.
module accum_reg
  import accum_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SAT       = 0,
  parameter int BLOCK_LEN = 8,
  parameter int CNT_W     = $clog2(BLOCK_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [2:0]              op,
  input  logic signed [WIDTH-1:0] D,
  output logic signed [WIDTH-1:0] Q,
  output logic                    ovf,
  output logic                    sticky_ovf,
  output logic                    zero,
  output logic                    neg,
  output logic [CNT_W-1:0]        cnt,
  output logic                    done,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

  logic signed [WIDTH-1:0] sum;
  logic                    sum_ovf;
  state_t                  state;

  accum_addsub #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_addsub (
    .a      (Q),
    .b      (D),
    .sub    (op == OP_SUB),
    .result (sum),
    .ovf    (sum_ovf)
  );

  // Single register stage: every accepted op lands on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q          <= '0;
      ovf        <= 1'b0;
      sticky_ovf <= 1'b0;
      cnt        <= '0;
      done       <= 1'b0;
      state      <= ST_IDLE;
    end else begin
      done <= 1'b0;
      if (en) begin
        case (op)
          OP_LOAD: begin
            Q     <= D;
            ovf   <= 1'b0;
            cnt   <= '0;
            state <= ST_ACC;
          end
          OP_ADD, OP_SUB: begin
            Q   <= sum;
            ovf <= sum_ovf;
            if (sum_ovf) sticky_ovf <= 1'b1;
            // Final op of a block keeps its sum in Q; only the counter rolls over.
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              state <= ST_ACC;
            end
          end
          OP_CLR: begin
            Q          <= '0;
            ovf        <= 1'b0;
            sticky_ovf <= 1'b0;
            cnt        <= '0;
            state      <= ST_IDLE;
          end
          OP_HOLD: ;
          default: ;
        endcase
      end
    end
  end

  assign zero = (Q == '0);
  assign neg  = Q[WIDTH-1];
  assign busy = (state == ST_ACC);

endmodule
